// File: rtl/dcache_wt_if.sv
// Word-wide backing-memory bus between the data cache and data memory.
// A request stays asserted with stable fields until the cycle mem_ack is high.
interface dcache_wt_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Misses and every store go to backing memory; stallM freezes the pipeline meanwhile.
module dcache_wt #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic [31:0] addrM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic [1:0]  dbgState,
    dcache_wt_if.master bus
);
    localparam int IB = $clog2(LINES);
    localparam int TW = 32 - IB - 2;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_t;

    state_t state, stateNext;

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tagArr  [LINES];
    logic [31:0]      dataArr [LINES];

    logic [IB-1:0] index;
    logic [TW-1:0] tag;
    logic          hit;
    logic          stallRaw;
    logic          unusedByteBits;

    assign index          = addrM[IB+1:2];
    assign tag            = addrM[31:IB+2];
    assign hit            = valid[index] && (tagArr[index] == tag);
    assign readdataM      = dataArr[index];
    assign dbgState       = state;
    assign unusedByteBits = ^addrM[1:0];

    // Stall is qualified by memreqM so a held-off pipeline never sees it.
    assign stallM = memreqM & stallRaw;

    always_comb begin
        stateNext = state;
        stallRaw  = 1'b0;
        case (state)
            IDLE: begin
                if (memreqM) begin
                    if (memwriteM) begin
                        stallRaw  = 1'b1;
                        stateNext = WRITE;
                    end else if (!hit) begin
                        stallRaw  = 1'b1;
                        stateNext = FILL;
                    end
                end
            end
            FILL: begin
                stallRaw = 1'b1;
                if (bus.mem_ack) stateNext = IDLE;
            end
            WRITE: begin
                // The store retires in the ack cycle, so release the pipeline then.
                stallRaw = ~bus.mem_ack;
                if (bus.mem_ack) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (memreqM && memwriteM) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= {addrM[31:2], 2'b00};
                        bus.mem_wdata <= writedataM;
                    end else if (memreqM && !hit) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= {addrM[31:2], 2'b00};
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        valid[index] <= 1'b1;
                        bus.mem_req  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) bus.mem_req <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays carry no reset; valid alone decides whether a line counts.
    always_ff @(posedge clk) begin
        if (!reset && bus.mem_ack) begin
            if (state == FILL) begin
                dataArr[index] <= bus.mem_rdata;
                tagArr[index]  <= tag;
            end else if (state == WRITE && hit) begin
                dataArr[index] <= writedataM;
            end
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: directed scenarios pinned with literal values, then random
// loads/stores checked against a word-memory model and a resident-line map.
module tb_dcache_wt;
    localparam int LINES = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreqM;
    logic        memwriteM;
    logic [31:0] addrM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic [1:0]  dbgState;

    dcache_wt_if bus();

    dcache_wt #(.LINES(LINES)) dut (
        .clk        (clk),
        .reset      (reset),
        .memreqM    (memreqM),
        .memwriteM  (memwriteM),
        .addrM      (addrM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .dbgState   (dbgState),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Backing memory contents: the truth every load must return (write-through).
    logic [31:0] memArr [logic [31:0]];
    // Expected bus requests {we, addr, wdata(stores only)} in issue order.
    logic [64:0] expQ [$];
    // Which word address each line holds, as the cache should see it.
    logic        resValid [LINES];
    logic [31:0] resAddr  [LINES];

    int          curW = 0;
    logic        idleAck = 1'b0;
    int          reqCount = 0;
    logic        lastWe;
    logic [31:0] lastAddr;
    logic [31:0] lastWdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Backing-memory responder: acks each request curW cycles after it appears.
    initial begin : responder
        bit busy = 1'b0;
        int cnt  = 0;
        logic [64:0] e;
        logic [64:0] a;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = curW;
                end
                if (cnt == 0) begin
                    bus.mem_ack = 1'b1;
                    busy        = 1'b0;
                    reqCount++;
                    lastWe    = bus.mem_we;
                    lastAddr  = bus.mem_addr;
                    lastWdata = bus.mem_wdata;
                    a = {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 32'h0};
                    if (expQ.size() == 0) begin
                        check("unexpected_req", bus.mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = expQ.pop_front();
                        check("req_we",    {31'h0, a[64]}, {31'h0, e[64]});
                        check("req_addr",  a[63:32], e[63:32]);
                        check("req_wdata", a[31:0],  e[31:0]);
                    end
                    if (bus.mem_we) memArr[bus.mem_addr] = bus.mem_wdata;
                    else            bus.mem_rdata = memRead(bus.mem_addr);
                end else begin
                    cnt--;
                end
            end else begin
                busy = 1'b0;
                bus.mem_ack   = idleAck;
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Per-cycle compare: load data, stall gating, bus hold and release.
    initial begin : compare
        logic        pReq = 1'b0, pAck = 1'b0, pRst = 1'b1, pWe = 1'b0;
        logic [31:0] pAddr = 32'h0, pWdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset && memreqM && !memwriteM && !stallM)
                check("load_data", readdataM, memRead({addrM[31:2], 2'b00}));
            if (!memreqM) check("stall_gated", {31'h0, stallM}, 32'h0);
            if (pReq && !pAck && !pRst && bus.mem_req) begin
                check("hold_we",    {31'h0, bus.mem_we}, {31'h0, pWe});
                check("hold_addr",  bus.mem_addr, pAddr);
                check("hold_wdata", bus.mem_wdata, pWdata);
            end
            if (pReq && pAck) check("req_drop", {31'h0, bus.mem_req}, 32'h0);
            pReq = bus.mem_req; pAck = bus.mem_ack; pRst = reset;
            pWe = bus.mem_we; pAddr = bus.mem_addr; pWdata = bus.mem_wdata;
        end
    end

    task automatic clearModel();
        for (int i = 0; i < LINES; i++) resValid[i] = 1'b0;
    endtask

    task automatic doReset(input int n);
        reset   = 1'b1;
        memreqM = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        reset = 1'b0;
        clearModel();
    endtask

    task automatic idle(input int n);
        memreqM = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic doAccess(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int w, output int stalls, output logic [31:0] rd);
        int          idx;
        logic [31:0] wa;
        bit          hitExp;
        bit          done;
        int          startReq;
        int          expStall;
        idx      = int'(addr[5:2]);
        wa       = {addr[31:2], 2'b00};
        hitExp   = !we && resValid[idx] && (resAddr[idx] == wa);
        expStall = we ? w + 1 : (hitExp ? 0 : w + 2);
        startReq = reqCount;
        if (!hitExp) expQ.push_back({we, wa, we ? wd : 32'h0});
        curW       = w;
        memreqM    = 1'b1;
        memwriteM  = we;
        addrM      = addr;
        writedataM = wd;
        stalls     = 0;
        rd         = 32'h0;
        done       = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (stallM) stalls++;
            else begin
                done = 1'b1;
                rd   = readdataM;
            end
            @(posedge clk);
            #2;
        end
        check("access_done", {31'h0, done}, 32'h1);
        check("stall_cycles", stalls, expStall);
        check("req_count", reqCount - startReq, hitExp ? 0 : 1);
        if (!we) check("access_rdata", rd, memRead(wa));
        if (!we && !hitExp) begin
            resValid[idx] = 1'b1;
            resAddr[idx]  = wa;
        end
        memreqM = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          st;
        logic [31:0] rd;
        logic [31:0] a;
        logic        we;
        memreqM = 1'b0; memwriteM = 1'b0; addrM = 32'h0; writedataM = 32'h0;
        reset = 1'b1;
        clearModel();
        memArr[32'h40]  = 32'hDEAD_BEEF;
        memArr[32'h440] = 32'hCAFE_F00D;

        // Reset values.
        @(posedge clk); #2;
        @(negedge clk);
        check("rst_stall", {31'h0, stallM}, 32'h0);
        check("rst_req",   {31'h0, bus.mem_req}, 32'h0);
        check("rst_we",    {31'h0, bus.mem_we}, 32'h0);
        check("rst_addr",  bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        doReset(1);

        // Cold load, then immediate reload hits.
        doAccess(1'b0, 32'h40, 32'h0, 2, st, rd);
        check("cold_stall", st, 4);
        check("cold_data", rd, 32'hDEAD_BEEF);
        check("cold_addr", lastAddr, 32'h40);
        doAccess(1'b0, 32'h40, 32'h0, 0, st, rd);
        check("reload_stall", st, 0);

        // Store hit updates the line.
        doAccess(1'b1, 32'h40, 32'h1234_5678, 0, st, rd);
        check("sthit_stall", st, 1);
        check("sthit_we", {31'h0, lastWe}, 32'h1);
        check("sthit_addr", lastAddr, 32'h40);
        check("sthit_wdata", lastWdata, 32'h1234_5678);
        doAccess(1'b0, 32'h43, 32'h0, 0, st, rd);
        check("sthit_reload_stall", st, 0);
        check("sthit_reload_data", rd, 32'h1234_5678);

        // Store miss does not allocate.
        doAccess(1'b1, 32'h80, 32'hAAAA_5555, 1, st, rd);
        check("stmiss_stall", st, 2);
        doAccess(1'b0, 32'h80, 32'h0, 1, st, rd);
        check("stmiss_load_stall", st, 3);
        check("stmiss_load_addr", lastAddr, 32'h80);
        check("stmiss_load_data", rd, 32'hAAAA_5555);

        // Aliasing: three fills at the same index.
        doReset(1);
        doAccess(1'b0, 32'h40, 32'h0, 1, st, rd);
        check("alias1_stall", st, 3);
        check("alias1_data", rd, 32'h1234_5678);
        doAccess(1'b0, 32'h440, 32'h0, 1, st, rd);
        check("alias2_stall", st, 3);
        check("alias2_data", rd, 32'hCAFE_F00D);
        doAccess(1'b0, 32'h40, 32'h0, 1, st, rd);
        check("alias3_stall", st, 3);
        check("alias3_data", rd, 32'h1234_5678);

        // Reset while a fill is outstanding.
        expQ.push_back({1'b0, 32'h200, 32'h0});
        curW = 20; memreqM = 1'b1; memwriteM = 1'b0; addrM = 32'h200;
        repeat (3) @(posedge clk);
        #2;
        check("midfill_req_up", {31'h0, bus.mem_req}, 32'h1);
        reset = 1'b1; memreqM = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check("midfill_req", {31'h0, bus.mem_req}, 32'h0);
        check("midfill_stall", {31'h0, stallM}, 32'h0);
        expQ.delete();
        clearModel();
        @(posedge clk); #2;
        doAccess(1'b0, 32'h40, 32'h0, 0, st, rd);
        check("post_reset_miss", st, 2);

        // Idle bus ack must be ignored.
        idleAck = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        idleAck = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'h0, stallM}, 32'h0);
        check("idle_req", {31'h0, bus.mem_req}, 32'h0);
        @(posedge clk); #2;
        doAccess(1'b0, 32'h40, 32'h0, 0, st, rd);
        check("idle_hit_stall", st, 0);
        check("idle_hit_data", rd, 32'h1234_5678);

        // Random mix over a small address pool to force hits and conflicts.
        for (int n = 0; n < 300; n++) begin
            a  = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, LINES - 1)),
                  2'($urandom_range(0, 3))};
            we = ($urandom_range(0, 9) < 3);
            doAccess(we, a, $urandom, $urandom_range(0, 3), st, rd);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(3);
        check("exp_queue_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
